// File: rtl/v_activation.sv
// Streaming element-wise activation (pass / ReLU / leaky ReLU / clamp) over chunked vectors.
// States: IDLE | expecting chunk 0 of a vector ; RUN | expecting chunks 1..NChunks-1
module v_activation #(
  parameter int InVecLength = 64,
  parameter int NBits = 16,
  parameter int WorkingRegs = 4,
  parameter int LeakShift = 7,
  parameter logic signed [NBits-1:0] ClampMax = 16'sd4096
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [1:0]                           mode_in,
  input  logic                                 in_data_ready,
  input  logic signed [WorkingRegs*NBits-1:0]  in_data,
  output logic                                 req_chunk_in,
  input  logic                                 out_ready_in,
  output logic signed [WorkingRegs*NBits-1:0]  write_out_data,
  output logic                                 req_chunk_out,
  output logic                                 out_vector_valid,
  output logic [$clog2(InVecLength+1)-1:0]     neg_count
);

  localparam int NChunks = (InVecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int IdxW = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam int TailLanes = InVecLength - (NChunks - 1) * WorkingRegs;
  localparam int CntW = $clog2(InVecLength + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunks - 1);
  localparam logic signed [NBits-1:0] NegClamp = -ClampMax;

  localparam logic [1:0] ModePass  = 2'd0;
  localparam logic [1:0] ModeRelu  = 2'd1;
  localparam logic [1:0] ModeLeaky = 2'd2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state, state_nx;
  logic [IdxW-1:0]                 idx, idx_nx;
  logic [1:0]                      mode_q, mode_nx, mode_eff;
  logic [CntW-1:0]                 neg_acc, neg_acc_nx, chunk_neg, neg_total;
  logic                            acc, last_chunk;
  logic signed [WorkingRegs*NBits-1:0] act_data;
  logic signed [NBits-1:0]         lane_x, lane_y;
  logic                            lane_ok;

  // A new chunk is taken only if the output register is empty or draining this cycle.
  assign acc = in_data_ready & (~req_chunk_out | out_ready_in) & ~rst_in;
  assign req_chunk_in = acc;
  assign last_chunk = (idx == LastIdx);
  assign mode_eff = (state == IDLE) ? mode_in : mode_q;

  always_comb begin
    chunk_neg = '0;
    act_data = '0;
    lane_x = '0;
    lane_y = '0;
    lane_ok = 1'b0;
    for (int i = 0; i < WorkingRegs; i++) begin
      lane_x = in_data[i*NBits +: NBits];
      lane_ok = !last_chunk || (i < TailLanes);
      case (mode_eff)
        ModePass:  lane_y = lane_x;
        ModeRelu:  lane_y = (lane_x < 0) ? '0 : lane_x;
        ModeLeaky: lane_y = (lane_x < 0) ? (lane_x >>> LeakShift) : lane_x;
        default: begin
          if (lane_x > ClampMax)
            lane_y = ClampMax;
          else if (lane_x < NegClamp)
            lane_y = NegClamp;
          else
            lane_y = lane_x;
        end
      endcase
      // Tail lanes past the end of the vector are forced to zero and not counted.
      if (!lane_ok)
        lane_y = '0;
      if (lane_ok && (lane_x < 0))
        chunk_neg = chunk_neg + CntW'(1);
      act_data[i*NBits +: NBits] = lane_y;
    end
  end

  assign neg_total = neg_acc + chunk_neg;

  always_comb begin
    state_nx = state;
    idx_nx = idx;
    mode_nx = mode_q;
    neg_acc_nx = neg_acc;
    if (acc) begin
      if (state == IDLE)
        mode_nx = mode_in;
      if (last_chunk) begin
        state_nx = IDLE;
        idx_nx = '0;
        neg_acc_nx = '0;
      end else begin
        state_nx = RUN;
        idx_nx = idx + IdxW'(1);
        neg_acc_nx = neg_total;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      idx <= '0;
      mode_q <= '0;
      neg_acc <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      mode_q <= mode_nx;
      neg_acc <= neg_acc_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      write_out_data <= '0;
      req_chunk_out <= 1'b0;
      out_vector_valid <= 1'b0;
      neg_count <= '0;
    end else if (acc) begin
      write_out_data <= act_data;
      req_chunk_out <= 1'b1;
      out_vector_valid <= last_chunk;
      if (last_chunk)
        neg_count <= neg_total;
    end else if (out_ready_in) begin
      req_chunk_out <= 1'b0;
      out_vector_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v_activation.sv
// Bench for v_activation: three instances (8, 10 and 3 element vectors, 4 lanes) driven
// from a table of chunks; expected chunks go through a scoreboard queue.
module tb_v_activation;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in, in_data_ready, out_ready_in;
  logic [1:0]  mode_in;
  logic [63:0] in_data;
  int          sel;

  logic        rdy0, rdy1, rdy2, rci0, rci1, rci2, rco0, rco1, rco2, ovv0, ovv1, ovv2;
  logic [63:0] wd0, wd1, wd2;
  logic [3:0]  nc0, nc1;
  logic [1:0]  nc2;

  logic        rci_m, rco_m, ovv_m;
  logic [63:0] wd_m;
  int          nc_m;

  assign rdy0 = in_data_ready & (sel == 0);
  assign rdy1 = in_data_ready & (sel == 1);
  assign rdy2 = in_data_ready & (sel == 2);

  v_activation #(.InVecLength(8), .NBits(16), .WorkingRegs(4), .LeakShift(7), .ClampMax(16'sd4096)) dut8 (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .in_data_ready(rdy0), .in_data(in_data),
    .req_chunk_in(rci0), .out_ready_in(out_ready_in), .write_out_data(wd0),
    .req_chunk_out(rco0), .out_vector_valid(ovv0), .neg_count(nc0));

  v_activation #(.InVecLength(10), .NBits(16), .WorkingRegs(4), .LeakShift(7), .ClampMax(16'sd4096)) dut10 (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .in_data_ready(rdy1), .in_data(in_data),
    .req_chunk_in(rci1), .out_ready_in(out_ready_in), .write_out_data(wd1),
    .req_chunk_out(rco1), .out_vector_valid(ovv1), .neg_count(nc1));

  v_activation #(.InVecLength(3), .NBits(16), .WorkingRegs(4), .LeakShift(7), .ClampMax(16'sd4096)) dut3 (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .in_data_ready(rdy2), .in_data(in_data),
    .req_chunk_in(rci2), .out_ready_in(out_ready_in), .write_out_data(wd2),
    .req_chunk_out(rco2), .out_vector_valid(ovv2), .neg_count(nc2));

  always_comb begin
    rci_m = rci0; rco_m = rco0; ovv_m = ovv0; wd_m = wd0; nc_m = int'(nc0);
    if (sel == 1) begin
      rci_m = rci1; rco_m = rco1; ovv_m = ovv1; wd_m = wd1; nc_m = int'(nc1);
    end else if (sel == 2) begin
      rci_m = rci2; rco_m = rco2; ovv_m = ovv2; wd_m = wd2; nc_m = int'(nc2);
    end
  end

  typedef struct {
    logic [63:0] d;
    logic        last;
    int          negc;
  } exp_t;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    logic [63:0] din;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input logic last, input int negc);
    exp_t e;
    e.d = d; e.last = last; e.negc = negc;
    return e;
  endfunction

  task automatic add(input int s, input logic [1:0] m, input logic [63:0] din, input logic [63:0] dout,
                     input logic last, input int negc);
    vec_t v;
    v.sel = s; v.mode = m; v.din = din; v.e = mk(dout, last, negc);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_in && rco_m && out_ready_in) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected nothing at %0t", wd_m, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", wd_m, mon_e.d);
        chk("out_vector_valid", 64'(ovv_m), 64'(mon_e.last));
        if (mon_e.last)
          chk("neg_count", 64'(nc_m), 64'(mon_e.negc));
      end
    end
  end

  task automatic set_in(input logic [1:0] m, input logic [63:0] d);
    mode_in = m;
    in_data = d;
    in_data_ready = 1'b1;
  endtask

  // Returns at posedge+1 after the chunk is taken; inputs stay asserted for the caller.
  task automatic wait_acc(input exp_t e, output int stall);
    stall = 0;
    forever begin
      @(negedge clk);
      if (rci_m) begin
        sb.push_back(e);
        break;
      end
      stall++;
      if (stall > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got no req_chunk_in expected one within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int s);
    in_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = s;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st;
    int cur;

    // len 8, leaky: floor shift, -1 stays -1
    add(0, 2, pk(-256, -1, 100, 0),       pk(-2, -1, 100, 0),        1'b0, 0);
    add(0, 2, pk(-128, 5, -32768, 7),     pk(-1, 5, -256, 7),        1'b1, 4);
    // len 8, clamp
    add(0, 3, pk(5000, -5000, 4096, -4097), pk(4096, -4096, 4096, -4096), 1'b0, 0);
    add(0, 3, pk(-4096, 4095, -1, 1),     pk(-4096, 4095, -1, 1),    1'b1, 4);
    // len 8, pass then ReLU
    add(0, 0, pk(1, 2, 3, 4),             pk(1, 2, 3, 4),            1'b0, 0);
    add(0, 0, pk(-1, -2, -3, -4),         pk(-1, -2, -3, -4),        1'b1, 4);
    add(0, 1, pk(-7, 7, 0, -32768),       pk(0, 7, 0, 0),            1'b0, 0);
    add(0, 1, pk(32767, -1, 2, -3),       pk(32767, 0, 2, 0),        1'b1, 4);
    // len 10, ReLU, tail lanes excluded from count
    add(1, 1, pk(-5, -5, -5, -5),         pk(0, 0, 0, 0),            1'b0, 0);
    add(1, 1, pk(-5, -5, -5, -5),         pk(0, 0, 0, 0),            1'b0, 0);
    add(1, 1, pk(-5, -5, -5, -5),         pk(0, 0, 0, 0),            1'b1, 10);
    // len 10, leaky with tail
    add(1, 2, pk(-129, -128, -127, 127),  pk(-2, -1, -1, 127),       1'b0, 0);
    add(1, 2, pk(300, -300, 32767, -32767), pk(300, -3, 32767, -256), 1'b0, 0);
    add(1, 2, pk(-1, -1, -9, -9),         pk(-1, -1, 0, 0),          1'b1, 7);
    // len 10, mode flips 1->0 mid-vector: whole vector ReLU, next vector pass
    add(1, 1, pk(-5, 3, -2, 8),           pk(0, 3, 0, 8),            1'b0, 0);
    add(1, 0, pk(-1, -1, 4, 4),           pk(0, 0, 4, 4),            1'b0, 0);
    add(1, 0, pk(6, -6, -7, -7),          pk(6, 0, 0, 0),            1'b1, 5);
    add(1, 0, pk(-5, 3, -2, 8),           pk(-5, 3, -2, 8),          1'b0, 0);
    add(1, 0, pk(-1, -1, 4, 4),           pk(-1, -1, 4, 4),          1'b0, 0);
    add(1, 0, pk(6, -6, -7, -7),          pk(6, -6, 0, 0),           1'b1, 5);
    // len 3 in 4 lanes: every chunk is a full vector, mode taken per chunk
    add(2, 0, pk(-1, 2, -3, -4),          pk(-1, 2, -3, 0),          1'b1, 2);
    add(2, 3, pk(5000, -1, 0, -9000),     pk(4096, -1, 0, 0),        1'b1, 1);
    add(2, 1, pk(-1, -1, -1, -1),         pk(0, 0, 0, 0),            1'b1, 3);

    sel = 0;
    rst_in = 1'b1;
    in_data_ready = 1'b0;
    out_ready_in = 1'b1;
    mode_in = 2'd0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_data", wd_m, 64'd0);
      chk("reset_req_out", 64'(rco_m), 64'd0);
      chk("reset_vec_valid", 64'(ovv_m), 64'd0);
      chk("reset_neg_count", 64'(nc_m), 64'd0);
    end
    rst_in = 1'b0;
    @(posedge clk);
    #1;

    cur = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel != cur) begin
        select(tbl[i].sel);
        cur = tbl[i].sel;
      end
      set_in(tbl[i].mode, tbl[i].din);
      wait_acc(tbl[i].e, st);
      chk("accept_stall", 64'(st), 64'd0);
    end

    // Backpressure on a mid-vector chunk and on the last chunk.
    select(0);
    set_in(0, pk(10, -20, 30, -40));
    wait_acc(mk(pk(10, -20, 30, -40), 1'b0, 0), st);
    out_ready_in = 1'b0;
    set_in(0, pk(50, 60, -70, 80));
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_in", 64'(rci_m), 64'd0);
      chk("stall_req_out", 64'(rco_m), 64'd1);
      chk("stall_data", wd_m, pk(10, -20, 30, -40));
    end
    @(posedge clk);
    #1;
    out_ready_in = 1'b1;
    wait_acc(mk(pk(50, 60, -70, 80), 1'b1, 3), st);
    in_data_ready = 1'b0;
    out_ready_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_last_req_out", 64'(rco_m), 64'd1);
      chk("stall_last_vec_valid", 64'(ovv_m), 64'd1);
      chk("stall_last_neg", 64'(nc_m), 64'd3);
      chk("stall_last_data", wd_m, pk(50, 60, -70, 80));
    end
    @(posedge clk);
    #1;
    out_ready_in = 1'b1;

    // Reset after chunk 1 of 3 discards the partial vector.
    select(1);
    set_in(1, pk(-5, -5, -5, -5));
    wait_acc(mk(pk(0, 0, 0, 0), 1'b0, 0), st);
    wait_acc(mk(pk(0, 0, 0, 0), 1'b0, 0), st);
    in_data_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    set_in(0, pk(1, 1, 1, 1));
    @(negedge clk);
    chk("reset_req_in", 64'(rci_m), 64'd0);
    #1;
    in_data_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_data", wd_m, 64'd0);
    chk("midreset_req_out", 64'(rco_m), 64'd0);
    chk("midreset_vec_valid", 64'(ovv_m), 64'd0);
    chk("midreset_neg", 64'(nc_m), 64'd0);
    rst_in = 1'b0;
    set_in(0, pk(1, -2, 3, -4));
    wait_acc(mk(pk(1, -2, 3, -4), 1'b0, 0), st);
    set_in(0, pk(-5, 6, -7, 8));
    wait_acc(mk(pk(-5, 6, -7, 8), 1'b0, 0), st);
    set_in(0, pk(9, -10, 11, -12));
    wait_acc(mk(pk(9, -10, 0, 0), 1'b1, 5), st);
    in_data_ready = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
